pkt_tx_framer: RTL and testbench

Transmit-side packet framer: the counterpart of the link's receive packet processor. Pulls payload bytes from a first-word-fall-through FIFO and drives a GMII-style byte stream (TXD/TX_EN/TX_ER) to the downstream PCS encoder. Every frame is emitted as preamble, SFD, payload, zero pad to minimum length, CRC-32 FCS, then a mandatory inter-packet gap. Underflow and oversize conditions are detected; an error-propagation symbol is emitted and the rest of the frame is drained.

---
 rtl/pkt_tx_framer.sv | 213 +++++++++++++++++++++
 tb/tb_pkt_tx_framer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_framer.sv
// pkt_tx_framer: transmit-side packet framer.
// Pulls payload bytes from a first-word-fall-through FIFO and emits a
// GMII-style byte stream: 7x preamble, SFD, payload, zero pad up to MIN_LEN,
// CRC-32 FCS (LSB byte first), then IFG_LEN idle cycles. FIFO underflow and
// oversize frames are aborted with one error-propagation symbol, and the rest
// of the frame is drained from the FIFO with TX_EN low.
//
// Ports
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   TX_REQ    frame available; sampled only in Idle
//   DIN       FIFO head byte (FWFT)
//   DIN_LAST  FIFO head byte is the last payload byte
//   EMPTY     FIFO empty
//   RD_EN     FIFO pop (combinational)
//   TXD       transmit byte (registered)
//   TX_EN     transmit enable (registered)
//   TX_ER     transmit error / propagation (registered)
//   ERR       one-cycle pulse on frame abort (registered)
//   DONE      one-cycle pulse with the last FCS byte (registered)
//   STATE     current state encoding, debug
module pkt_tx_framer #(
    parameter int MAX_COUNT = 896,
    parameter int MIN_LEN   = 60,
    parameter int IFG_LEN   = 12
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_REQ,
    input  logic [7:0] DIN,
    input  logic       DIN_LAST,
    input  logic       EMPTY,
    output logic       RD_EN,
    output logic [7:0] TXD,
    output logic       TX_EN,
    output logic       TX_ER,
    output logic       ERR,
    output logic       DONE,
    output logic [3:0] STATE
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PRE   = 4'd1,
        S_SFD   = 4'd2,
        S_PAY   = 4'd3,
        S_PAD   = 4'd4,
        S_FCS   = 4'd5,
        S_IFG   = 4'd6,
        S_ABORT = 4'd7,
        S_DRAIN = 4'd8
    } state_t;

    localparam logic [10:0] MAX_C = 11'(MAX_COUNT);
    localparam logic [10:0] MIN_C = 11'(MIN_LEN);
    localparam logic [10:0] IFG_C = 11'(IFG_LEN - 1);
    localparam logic [10:0] PRE_C = 11'd6;
    localparam logic [31:0] POLY  = 32'hEDB88320;

    state_t      state, state_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic [31:0] crc, crc_nxt;
    logic [31:0] fcs;
    logic [7:0]  txd_nxt;
    logic        tx_en_nxt, tx_er_nxt, err_nxt, done_nxt, rd_en;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    assign fcs   = ~crc;
    assign RD_EN = rd_en;
    assign STATE = state;

    // One counter serves every state that needs one; it is zeroed on each
    // transition except Payload->Pad, where it keeps counting toward MIN_LEN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        crc_nxt   = crc;
        txd_nxt   = 8'h00;
        tx_en_nxt = 1'b0;
        tx_er_nxt = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        rd_en     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (TX_REQ) state_nxt = S_PRE;
            end
            S_PRE: begin
                tx_en_nxt = 1'b1;
                txd_nxt   = 8'h55;
                if (cnt == PRE_C) begin
                    state_nxt = S_SFD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            S_SFD: begin
                tx_en_nxt = 1'b1;
                txd_nxt   = 8'hD5;
                crc_nxt   = 32'hFFFF_FFFF;
                cnt_nxt   = '0;
                state_nxt = S_PAY;
            end
            S_PAY: begin
                tx_en_nxt = 1'b1;
                // The abort symbol goes out on the same edge the fault is
                // seen, so TX_EN never drops and no byte is repeated; it is on
                // the wire while the FSM sits in Abort.
                if (EMPTY || cnt == MAX_C) begin
                    tx_er_nxt = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = S_ABORT;
                    cnt_nxt   = '0;
                end else begin
                    rd_en   = 1'b1;
                    txd_nxt = DIN;
                    crc_nxt = crc_next(crc, DIN);
                    cnt_nxt = cnt + 11'd1;
                    if (DIN_LAST) begin
                        if (cnt + 11'd1 < MIN_C) begin
                            state_nxt = S_PAD;
                        end else begin
                            state_nxt = S_FCS;
                            cnt_nxt   = '0;
                        end
                    end
                end
            end
            S_PAD: begin
                tx_en_nxt = 1'b1;
                crc_nxt   = crc_next(crc, 8'h00);
                if (cnt + 11'd1 >= MIN_C) begin
                    state_nxt = S_FCS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            S_FCS: begin
                tx_en_nxt = 1'b1;
                case (cnt[1:0])
                    2'd0:    txd_nxt = fcs[7:0];
                    2'd1:    txd_nxt = fcs[15:8];
                    2'd2:    txd_nxt = fcs[23:16];
                    default: txd_nxt = fcs[31:24];
                endcase
                if (cnt[1:0] == 2'd3) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IFG;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            S_IFG: begin
                if (cnt == IFG_C) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            S_ABORT: begin
                state_nxt = S_DRAIN;
                cnt_nxt   = '0;
            end
            S_DRAIN: begin
                cnt_nxt = '0;
                if (!EMPTY) begin
                    rd_en = 1'b1;
                    if (DIN_LAST) state_nxt = S_IFG;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            crc   <= '0;
            TXD   <= 8'h00;
            TX_EN <= 1'b0;
            TX_ER <= 1'b0;
            ERR   <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            crc   <= crc_nxt;
            TXD   <= txd_nxt;
            TX_EN <= tx_en_nxt;
            TX_ER <= tx_er_nxt;
            ERR   <= err_nxt;
            DONE  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Scoreboard bench for pkt_tx_framer. A queue-backed FWFT FIFO model feeds
// the DUT; expected wire symbols {ERR,DONE,TX_ER,TXD} are queued when a frame
// is loaded and popped on every TX_EN cycle. A second instance with MIN_LEN=0
// checks the unpadded "123456789" known-answer frame.
module tb_pkt_tx_framer;

    logic       clk = 1'b0;
    logic       rst, tx_req, tx_req0;
    logic [7:0] din;
    logic       din_last, empty;
    logic       rd_en, tx_en, tx_er, err, done;
    logic [7:0] txd;
    logic [3:0] state;
    logic       rd_en0, tx_en0, tx_er0, err0, done0;
    logic [7:0] txd0;
    logic [3:0] state0;

    always #5 clk = ~clk;

    pkt_tx_framer u_dut (
        .CLK(clk), .RST(rst), .TX_REQ(tx_req), .DIN(din), .DIN_LAST(din_last),
        .EMPTY(empty), .RD_EN(rd_en), .TXD(txd), .TX_EN(tx_en), .TX_ER(tx_er),
        .ERR(err), .DONE(done), .STATE(state)
    );

    pkt_tx_framer #(.MIN_LEN(0)) u_dut0 (
        .CLK(clk), .RST(rst), .TX_REQ(tx_req0), .DIN(din), .DIN_LAST(din_last),
        .EMPTY(empty), .RD_EN(rd_en0), .TXD(txd0), .TX_EN(tx_en0), .TX_ER(tx_er0),
        .ERR(err0), .DONE(done0), .STATE(state0)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0]  fifo[$];
    logic [7:0]  pl[$];
    logic [10:0] exp_q[$];
    int          exp_len[$];
    logic [9:0]  cap0[$];

    logic pend, prev_en, en_s, mon_off;
    logic [3:0] st_s;
    int run, zrun, last_gap, starts;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic refresh();
        if (fifo.size() == 0) begin
            empty = 1'b1; din = 8'h00; din_last = 1'b0;
        end else begin
            empty = 1'b0; din = fifo[0][7:0]; din_last = fifo[0][8];
        end
    endtask

    task automatic fill_pl(input int n, input int base);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'(base + i * 13));
    endtask

    task automatic load_fifo(input int from, input int to);
        for (int i = from; i < to; i++)
            fifo.push_back({(i == pl.size() - 1), pl[i]});
        refresh();
    endtask

    task automatic exp_hdr();
        for (int i = 0; i < 7; i++) exp_q.push_back(11'h055);
        exp_q.push_back(11'h0D5);
    endtask

    // Complete frame: header, payload, pad to 60, FCS with DONE on last byte.
    task automatic exp_good();
        logic [31:0] c;
        int n;
        c = 32'hFFFF_FFFF;
        exp_hdr();
        foreach (pl[i]) begin
            exp_q.push_back({3'b000, pl[i]});
            c = crc_ref(c, pl[i]);
        end
        for (int i = pl.size(); i < 60; i++) begin
            exp_q.push_back(11'h000);
            c = crc_ref(c, 8'h00);
        end
        c = ~c;
        exp_q.push_back({3'b000, c[7:0]});
        exp_q.push_back({3'b000, c[15:8]});
        exp_q.push_back({3'b000, c[23:16]});
        exp_q.push_back({3'b010, c[31:24]});
        n = (pl.size() > 60) ? pl.size() : 60;
        exp_len.push_back(12 + n);
    endtask

    // Aborted frame: header, n payload bytes, one TX_ER symbol with ERR.
    task automatic exp_abort(input int n);
        exp_hdr();
        for (int i = 0; i < n; i++) exp_q.push_back({3'b000, pl[i]});
        exp_q.push_back(11'h500);
        exp_len.push_back(8 + n + 1);
    endtask

    task automatic tick();
        @(negedge clk);
        pend = rd_en && !empty;
        en_s = tx_en;
        st_s = state;
        if (tx_en0) cap0.push_back({done0, tx_er0, txd0});
        if (tx_en && !prev_en) begin
            last_gap = zrun;
            starts++;
            run = 0;
        end
        if (!mon_off) begin
            if (tx_en) begin
                if (exp_q.size() == 0) chk("exp_q_size", 32'(exp_q.size()), 32'd1);
                else chk("wire", {err, done, tx_er, txd}, exp_q.pop_front());
            end else begin
                chk("idle_out", {err, done, tx_er, txd}, 0);
                if (prev_en && exp_len.size() > 0) chk("frame_len", run, exp_len.pop_front());
            end
        end
        if (tx_en) begin
            run++; zrun = 0;
        end else begin
            zrun++;
        end
        prev_en = tx_en;
        @(posedge clk);
        #1;
        if (pend) void'(fifo.pop_front());
        refresh();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(exp_q.size() == 0 && exp_len.size() == 0 && st_s == 4'd0) && n < budget);
        if (n >= budget) begin
            chk("timeout_q", exp_q.size(), 0);
            chk("timeout_st", st_s, 0);
        end
    endtask

    task automatic req_pulse();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
    endtask

    initial begin
        logic [9:0] ka[$];
        int n, s0;
        rst = 1'b1; tx_req = 1'b0; tx_req0 = 1'b0;
        mon_off = 1'b1; prev_en = 1'b0; run = 0; zrun = 0; last_gap = 0; starts = 0;
        refresh();
        repeat (3) tick();
        chk("rst_out", {tx_en, tx_er, err, done, rd_en, txd}, 0);
        chk("rst_state", state, 0);
        rst = 1'b0;
        mon_off = 1'b0;
        tick();

        // Known-answer "123456789": padded on u_dut, unpadded on u_dut0.
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
        load_fifo(0, 9);
        exp_good();
        tx_req = 1'b1; tx_req0 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            tx_req = 1'b0; tx_req0 = 1'b0;
        end while (!en_s && n < 20);
        chk("req_lat", n, 3);
        wait_idle(200);
        for (int i = 0; i < 7; i++) ka.push_back(10'h055);
        ka.push_back(10'h0D5);
        for (int i = 0; i < 9; i++) ka.push_back(10'h031 + 10'(i));
        ka.push_back(10'h026); ka.push_back(10'h039);
        ka.push_back(10'h0F4); ka.push_back(10'h2CB);
        chk("ka_len", cap0.size(), 21);
        for (int i = 0; i < 21 && i < cap0.size(); i++) chk("ka_byte", cap0[i], ka[i]);
        chk("ka_state", state0, 0);

        // Short payload padded to 60.
        fill_pl(10, 8'h10);
        load_fifo(0, 10);
        exp_good();
        req_pulse();
        wait_idle(200);

        // Underflow after 5 bytes, late remainder drained, then a clean frame.
        fill_pl(8, 8'h40);
        load_fifo(0, 5);
        exp_abort(5);
        req_pulse();
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("uf_abort_seen", exp_q.size(), 0);
        repeat (3) tick();
        chk("uf_drain_state", state, 8);
        load_fifo(5, 8);
        wait_idle(200);
        chk("uf_fifo_drained", fifo.size(), 0);
        fill_pl(20, 8'h80);
        load_fifo(0, 20);
        exp_good();
        req_pulse();
        wait_idle(200);

        // Oversize 897 aborts after 896; exactly 896 is legal.
        fill_pl(897, 8'h01);
        load_fifo(0, 897);
        exp_abort(896);
        req_pulse();
        wait_idle(2000);
        chk("ovs_fifo_drained", fifo.size(), 0);
        fill_pl(896, 8'h02);
        load_fifo(0, 896);
        exp_good();
        req_pulse();
        wait_idle(2000);

        // Back-to-back with TX_REQ held: 60 (no pad) then 61 bytes.
        fill_pl(60, 8'h03);
        load_fifo(0, 60);
        exp_good();
        fill_pl(61, 8'h04);
        load_fifo(0, 61);
        exp_good();
        s0 = starts;
        tx_req = 1'b1;
        n = 0;
        while (starts < s0 + 2 && n < 400) begin
            tick();
            n++;
        end
        tx_req = 1'b0;
        chk("b2b_starts", starts - s0, 2);
        chk("b2b_gap", last_gap, 13);
        wait_idle(300);

        // Reset during Payload truncates the frame; the next frame is clean.
        fill_pl(30, 8'h05);
        load_fifo(0, 30);
        exp_good();
        req_pulse();
        n = 0;
        while (st_s != 4'd3 && n < 50) begin
            tick();
            n++;
        end
        repeat (4) tick();
        rst = 1'b1;
        mon_off = 1'b1;
        exp_q.delete();
        exp_len.delete();
        tick();
        chk("mid_rst_out", {tx_en, tx_er, err, done, rd_en, txd}, 0);
        chk("mid_rst_state", state, 0);
        rst = 1'b0;
        mon_off = 1'b0;
        fifo.delete();
        refresh();
        tick();
        fill_pl(15, 8'h06);
        load_fifo(0, 15);
        exp_good();
        req_pulse();
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
